temporizador_ctrl: RTL and testbench
====================================

# temporizador_ctrl

Programmable interval-timer controller that sequences a 4-bit synchronous up-counter datapath. It accepts start/stop commands, captures a terminal count, clears and enables the counter, and flags completion. It supports one-shot and periodic modes. It sits between front-panel or host control logic and the counter, and is the only block that drives the counter's clear and enable.

## Interface
- WIDTH, 4, width of count, limit and interval tally
- clock  in  1  system clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-low; forces IDLE and clears all registers
- start  in  1  level-sampled command; honoured only in IDLE
- stop  in  1  level-sampled abort; honoured in LOAD, COUNT and DONE; has priority over start
- periodic  in  1  sampled in DONE: 1 = reload and run again, 0 = return to IDLE
- limit  in  WIDTH  terminal count, captured into lim_reg on the edge that accepts start
- Q  out  WIDTH  current count from the datapath
- busy  out  1  high in LOAD, COUNT and DONE
- done  out  1  high only in DONE (one cycle per completed interval)
- ciclos  out  WIDTH  number of completed intervals since last start; wraps 15 -> 0
- state  out  2  current FSM state, for debug and verification

## Operation
- Reset (async, reset=0): state=IDLE, Q=0, lim_reg=0, ciclos=0, busy=0, done=0. Held while reset=0. The first edge after release behaves as in IDLE.
- IDLE:
  - start=1 and stop=0 -> LOAD; lim_reg<=limit; ciclos<=0; Q<=0.
  - start=1 with stop=1 -> stay in IDLE.
- LOAD: counter cleared and not enabled. -> COUNT unconditionally, unless stop.
- COUNT:
  - Q==lim_reg -> DONE, Q holds.
  - Otherwise Q<=Q+1.
  - The compare happens before the increment, so Q never exceeds lim_reg and the datapath never wraps inside an interval.
- DONE: done=1; ciclos<=ciclos+1 on the exit edge.
  - periodic=1 -> LOAD, Q<=0.
  - periodic=0 -> IDLE, Q<=0.
- stop=1 in LOAD, COUNT or DONE -> IDLE next edge with Q<=0. No done. ciclos is not incremented, but it keeps its value.
- While busy, start is ignored and limit is ignored; lim_reg holds the captured value.
- limit=0: COUNT sees Q==0 at once -> DONE on the next edge.
- Encoding: IDLE=2'b00, LOAD=2'b01, COUNT=2'b10, DONE=2'b11. Unreachable codes do not exist, because all four are used.

## Timing
- Edge E0 accepts start -> LOAD.
- E1 -> COUNT, Q=0.
- E2 through E(1+lim): Q steps 1..lim.
- E(2+lim) -> DONE, done high for exactly one clock.
- E(3+lim) -> LOAD or IDLE.
- One-shot latency from accepting edge to done asserted: lim+2 edges.
- Periodic interval: lim+3 clocks, done-to-done.
- Outputs are Moore registered functions of state and datapath. There is no combinational path from inputs to outputs.
- Asynchronous reset during any state takes effect immediately, without waiting for an edge. An interval in progress is lost and produces no done.

## Structure
- Shared include (`temporizador_defs.vh`): state encodings and the WIDTH default.
- Sub-module `contador_carga_4bits`:
  - Ports: clock, reset (async, active-low), clear (sync), enable, Q[WIDTH].
  - clear has priority over enable; enable=1 increments Q.
- Controller: FSM, lim_reg, comparator, ciclos register; drives clear/enable from next-state.

## Test plan
- Reset then idle: reset=0 mid-run -> Q=0, state=00, busy=0, done=0 immediately; start=0 for 10 clocks -> all outputs unchanged.
- One-shot, limit=5, periodic=0: start one clock -> Q sequence 0,0,1,2,3,4,5,5 and done high 7 edges after acceptance for exactly 1 clock, then IDLE, ciclos=1.
- Periodic, limit=3, periodic=1: done pulses every 6 clocks; after 17 intervals ciclos=1 (wrap); change limit to 9 mid-run -> period stays 6.
- Boundaries: limit=0 -> done 2 edges after acceptance; limit=15 -> Q reaches 15, no wrap to 0 before DONE.
- Stop at Q=2 with limit=7 -> IDLE next edge, Q=0, no done pulse, ciclos unchanged; start with stop=1 in IDLE -> stays IDLE.
- Start held high through whole one-shot run (limit=2) -> ignored while busy; re-accepted on the first edge in IDLE, ciclos reset to 0.

Source files
------------

// File: rtl/temporizador_ctrl_pkg.sv
// Shared definitions for the interval-timer controller: data width and FSM state encoding.
package temporizador_ctrl_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/temporizador_ctrl_if.sv
// Control/status bundle between host logic (master) and the timer controller (slave).
interface temporizador_ctrl_if;
    import temporizador_ctrl_pkg::*;

    logic             start;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ciclos;
    logic [1:0]       state;

    modport master (
        output start, stop, periodic, limit,
        input  Q, busy, done, ciclos, state
    );

    modport slave (
        input  start, stop, periodic, limit,
        output Q, busy, done, ciclos, state
    );

endinterface

// File: rtl/temporizador_ctrl_contador.sv
// Up-counter datapath with synchronous clear (priority) and enable; state moves on the falling edge.
module contador_carga_4bits
    import temporizador_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] Q
);

    logic [CNT_WIDTH-1:0] count_q;

    // Count register: clear wins over enable, reset is asynchronous and active-low
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign Q = count_q;

endmodule

// File: rtl/temporizador_ctrl.sv
// Interval-timer controller: sequences the counter through LOAD/COUNT/DONE, tracks completed intervals.
module temporizador_ctrl
    import temporizador_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    temporizador_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] ciclos_q, ciclos_d;
    logic [WIDTH-1:0] countQ;
    logic             clear, enable;
    logic             busy, done;
    logic             accept;
    logic             atLimit;

    assign accept  = (state_q == IDLE) && bus.start && !bus.stop;
    assign atLimit = (countQ == lim_q);

    contador_carga_4bits #(
        .CNT_WIDTH(WIDTH)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .Q      (countQ)
    );

    // State register, moves on the falling edge
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; stop aborts any active phase and beats start/periodic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = bus.stop ? IDLE : COUNT;
            COUNT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (atLimit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = bus.periodic ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter control follows the next state: count only while staying in COUNT, hold into DONE, clear otherwise
    always_comb begin
        clear  = !((state_d == COUNT) || (state_d == DONE));
        enable = (state_q == COUNT) && (state_d == COUNT);
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
    end

    // Next values for captured limit and interval tally; tally bumps only on a normal DONE exit
    always_comb begin
        lim_d    = lim_q;
        ciclos_d = ciclos_q;
        if (accept) begin
            lim_d    = bus.limit;
            ciclos_d = '0;
        end else if ((state_q == DONE) && !bus.stop) begin
            ciclos_d = ciclos_q + WIDTH'(1);
        end
    end

    // Limit and tally registers
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            lim_q    <= '0;
            ciclos_q <= '0;
        end else begin
            lim_q    <= lim_d;
            ciclos_q <= ciclos_d;
        end
    end

    assign bus.Q      = countQ;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.ciclos = ciclos_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_temporizador_ctrl.sv
// Scoreboard bench for temporizador_ctrl: a cycle model pushes expected outputs per falling edge.
module tb_temporizador_ctrl;
    import temporizador_ctrl_pkg::*;

    typedef struct {
        int q;
        int st;
        int busy;
        int done;
        int cic;
    } expect_t;

    logic clock;
    logic reset;

    temporizador_ctrl_if bus();

    temporizador_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int      checks   = 0;
    int      failures = 0;
    expect_t expQ[$];
    int      doneCyc[$];
    int      cyc  = 0;
    int      maxQ = 0;
    int      cA;

    int mState, mQ, mLim, mCic;

    // Free-running clock; the DUT acts on falling edges, the bench samples on rising edges
    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mQ     = 0;
        mLim   = 0;
        mCic   = 0;
    endtask

    // Advance the reference model by one falling edge and queue the outputs that edge should produce
    task automatic modelEdge();
        case (mState)
            0: if (bus.start && !bus.stop) begin
                   mState = 1; mLim = int'(bus.limit); mCic = 0; mQ = 0;
               end
            1: begin
                   mState = bus.stop ? 0 : 2;
                   mQ     = 0;
               end
            2: if (bus.stop) begin
                   mState = 0; mQ = 0;
               end else if (mQ == mLim) begin
                   mState = 3;
               end else begin
                   mQ = mQ + 1;
               end
            default: begin
                   if (!bus.stop) begin
                       mCic   = (mCic + 1) % 16;
                       mState = bus.periodic ? 1 : 0;
                   end else begin
                       mState = 0;
                   end
                   mQ = 0;
               end
        endcase
        expQ.push_back('{mQ, mState, int'(mState != 0), int'(mState == 3), mCic});
    endtask

    task automatic stepCycle();
        expect_t e;
        modelEdge();
        @(negedge clock);
        @(posedge clock);
        #1;
        cyc++;
        checkOutput("sbDepth", expQ.size(), 1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("Q",      int'(bus.Q),      e.q);
            checkOutput("state",  int'(bus.state),  e.st);
            checkOutput("busy",   int'(bus.busy),   e.busy);
            checkOutput("done",   int'(bus.done),   e.done);
            checkOutput("ciclos", int'(bus.ciclos), e.cic);
        end
        if (bus.done) doneCyc.push_back(cyc);
        if (int'(bus.Q) > maxQ) maxQ = int'(bus.Q);
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic per, input int lim, input int n);
        bus.start    = s;
        bus.stop     = p;
        bus.periodic = per;
        bus.limit    = lim[3:0];
        repeat (n) stepCycle();
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.periodic = 1'b0;
        bus.limit    = '0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rstQ",     int'(bus.Q),      0);
        checkOutput("rstState", int'(bus.state),  0);
        checkOutput("rstBusy",  int'(bus.busy),   0);
        checkOutput("rstDone",  int'(bus.done),   0);
        checkOutput("rstCic",   int'(bus.ciclos), 0);
        reset = 1'b1;

        // Idle with start low for 10 clocks
        applyStimulus(0, 0, 0, 0, 10);

        // One-shot, limit 5
        doneCyc.delete();
        cA = cyc + 1;
        applyStimulus(1, 0, 0, 5, 1);
        applyStimulus(0, 0, 0, 5, 9);
        checkOutput("osDoneCount", doneCyc.size(), 1);
        if (doneCyc.size() > 0) checkOutput("osLatency", doneCyc[0] - cA, 7);
        checkOutput("osCiclos", int'(bus.ciclos), 1);

        // Periodic, limit 3, 17 intervals then limit changed mid-run
        doneCyc.delete();
        applyStimulus(1, 0, 1, 3, 1);
        applyStimulus(0, 0, 1, 3, 102);
        checkOutput("perWrap", int'(bus.ciclos), 1);
        applyStimulus(0, 0, 1, 9, 12);
        checkOutput("perCount", doneCyc.size(), 19);
        for (int i = 1; i < doneCyc.size(); i++) begin
            checkOutput("perPeriod", doneCyc[i] - doneCyc[i-1], 6);
        end
        applyStimulus(0, 1, 1, 9, 1);
        checkOutput("perStopped", int'(bus.state), 0);

        // limit 0
        doneCyc.delete();
        cA = cyc + 1;
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 4);
        checkOutput("lim0Count", doneCyc.size(), 1);
        if (doneCyc.size() > 0) checkOutput("lim0Latency", doneCyc[0] - cA, 2);

        // limit 15
        doneCyc.delete();
        maxQ = 0;
        cA   = cyc + 1;
        applyStimulus(1, 0, 0, 15, 1);
        applyStimulus(0, 0, 0, 15, 19);
        checkOutput("lim15Max", maxQ, 15);
        checkOutput("lim15Count", doneCyc.size(), 1);
        if (doneCyc.size() > 0) checkOutput("lim15Latency", doneCyc[0] - cA, 17);

        // Stop at Q=2 with limit 7
        doneCyc.delete();
        applyStimulus(1, 0, 0, 7, 1);
        applyStimulus(0, 0, 0, 7, 3);
        checkOutput("stopAtQ", int'(bus.Q), 2);
        applyStimulus(0, 1, 0, 7, 1);
        checkOutput("stopState", int'(bus.state), 0);
        checkOutput("stopQ", int'(bus.Q), 0);
        checkOutput("stopCic", int'(bus.ciclos), 0);
        applyStimulus(0, 0, 0, 7, 3);
        checkOutput("stopNoDone", doneCyc.size(), 0);

        // start together with stop in IDLE
        applyStimulus(1, 1, 0, 4, 2);
        checkOutput("startStop", int'(bus.state), 0);

        // start held through a one-shot run, limit 2
        applyStimulus(1, 0, 0, 2, 6);
        checkOutput("heldCicAfterRun", int'(bus.ciclos), 1);
        applyStimulus(1, 0, 0, 2, 1);
        checkOutput("heldReaccept", int'(bus.state), 1);
        checkOutput("heldCicCleared", int'(bus.ciclos), 0);
        applyStimulus(0, 0, 0, 2, 6);

        // Asynchronous reset mid-run
        applyStimulus(1, 0, 0, 9, 1);
        applyStimulus(0, 0, 0, 9, 3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstQ",     int'(bus.Q),     0);
        checkOutput("midRstState", int'(bus.state), 0);
        checkOutput("midRstBusy",  int'(bus.busy),  0);
        checkOutput("midRstDone",  int'(bus.done),  0);
        expQ.delete();
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 10);

        checkOutput("sbDrained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
